dcache_nway_wb: RTL and testbench

Parametrised N-way set-associative write-back, write-allocate data cache. It sits between the CPU memory stage and the AXI4 interconnect, and adds per-request uncached bypass. Requests are blocking, with one outstanding request at a time. Dirty victims are written back with an AXI burst, then the line is refilled with an AXI burst, and store data is merged into the refill beat that carries the target word.

---
 rtl/dcache_pkg.sv | 39 +++
 rtl/dcache_victim_sel.sv | 25 ++
 rtl/dcache_nway_wb.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_dcache_nway_wb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, AXI constants and width helpers for the N-way write-back data cache.
package dcache_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_WB_AW, S_WB_W, S_WB_B, S_RF_AR, S_RF_R,
    S_UC_AR, S_UC_R, S_UC_AW, S_UC_W, S_UC_B, S_RESP
  } state_t;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int off_width(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int line_words, input int sets);
    return 30 - $clog2(line_words) - $clog2(sets);
  endfunction

  // A direct-mapped cache still needs a 1-bit way index to keep vectors legal.
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = wen[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Replacement choice: lowest-numbered invalid way, else the set's round-robin pointer.
module dcache_victim_sel
  import dcache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = way_width(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr_ptr,
  output logic [WAY_W-1:0] victim
);

  // Scan from the top so the lowest invalid way wins
  always_comb begin
    victim = rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim = WAY_W'(w);
      end else begin
        victim = victim;
      end
    end
  end

endmodule

// File: rtl/dcache_nway_wb.sv
// Blocking N-way set-associative write-back/write-allocate data cache with AXI4 burst
// write-back and refill, plus single-beat uncached bypass.
module dcache_nway_wb
  import dcache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_uncached,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam int OFF_W = off_width(LINE_WORDS);
  localparam int IDX_W = idx_width(SETS);
  localparam int TAG_W = tag_width(LINE_WORDS, SETS);
  localparam int WAY_W = way_width(WAYS);
  localparam logic [7:0]       LINE_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

  state_t             state;
  logic [31:2]        cur_addr;
  logic [3:0]         cur_wen;
  logic [31:0]        cur_wdata;
  logic [OFF_W-1:0]   beat;
  logic [WAY_W-1:0]   victim_way;
  logic [31:0]        captured;

  logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];
  logic [31:0]        data_mem [WAYS][SETS][LINE_WORDS];
  logic [WAYS-1:0]    valid_bits [SETS];
  logic [WAYS-1:0]    dirty_bits [SETS];
  logic [WAY_W-1:0]   rr_ptr [SETS];

  logic [TAG_W-1:0]   cur_tag;
  logic [IDX_W-1:0]   cur_idx;
  logic [OFF_W-1:0]   cur_off;
  logic [31:0]        line_base;
  logic               is_store;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim_sel_way;
  logic [31:0]        hit_word;
  logic [31:0]        beat_word;
  logic [31:0]        load_word;
  logic [OFF_W-1:0]   beat_next;
  logic [WAY_W-1:0]   rr_next;

  assign cur_tag   = cur_addr[31 -: TAG_W];
  assign cur_idx   = cur_addr[2+OFF_W +: IDX_W];
  assign cur_off   = cur_addr[2 +: OFF_W];
  assign line_base = {cur_addr[31:2+OFF_W], {(OFF_W+2){1'b0}}};
  assign is_store  = |cur_wen;
  assign hit_word  = data_mem[hit_way][cur_idx][cur_off];
  assign beat_next = beat + 1'b1;
  assign rr_next   = (rr_ptr[cur_idx] == LAST_WAY) ? '0 : rr_ptr[cur_idx] + 1'b1;
  // Store data only lands in the beat that carries the addressed word.
  assign beat_word = merge_bytes(rdata, cur_wdata, (beat == cur_off) ? cur_wen : 4'h0);
  assign load_word = (beat == cur_off) ? rdata : captured;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_bits[cur_idx][w] && (tag_mem[w][cur_idx] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end else begin
        hit     = hit;
        hit_way = hit_way;
      end
    end
  end

  dcache_victim_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim_sel (
    .valid  (valid_bits[cur_idx]),
    .rr_ptr (rr_ptr[cur_idx]),
    .victim (victim_sel_way)
  );

  // Control FSM, registered CPU/AXI outputs and cache array updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      araddr     <= 32'h0;
      arlen      <= 8'h0;
      arsize     <= 3'h0;
      arburst    <= 2'h0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= 32'h0;
      awlen      <= 8'h0;
      awsize     <= 3'h0;
      awburst    <= 2'h0;
      awvalid    <= 1'b0;
      wdata      <= 32'h0;
      wstrb      <= 4'h0;
      wlast      <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      cur_addr   <= 30'h0;
      cur_wen    <= 4'h0;
      cur_wdata  <= 32'h0;
      beat       <= '0;
      victim_way <= '0;
      captured   <= 32'h0;
      for (int s = 0; s < SETS; s++) begin
        valid_bits[s] <= '0;
        dirty_bits[s] <= '0;
        rr_ptr[s]     <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            cur_addr  <= req_addr[31:2];
            cur_wen   <= req_wen;
            cur_wdata <= req_wdata;
            if (req_uncached && (req_wen == 4'h0)) begin
              state   <= S_UC_AR;
              arvalid <= 1'b1;
              araddr  <= req_addr;
              arlen   <= 8'h0;
              arsize  <= AXI_SIZE_WORD;
              arburst <= AXI_BURST_INCR;
            end else if (req_uncached) begin
              state   <= S_UC_AW;
              awvalid <= 1'b1;
              awaddr  <= req_addr;
              awlen   <= 8'h0;
              awsize  <= AXI_SIZE_WORD;
              awburst <= AXI_BURST_INCR;
            end else begin
              state <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            if (is_store) begin
              data_mem[hit_way][cur_idx][cur_off] <= merge_bytes(hit_word, cur_wdata, cur_wen);
              dirty_bits[cur_idx][hit_way]        <= 1'b1;
              resp_rdata                          <= 32'h0;
            end else begin
              resp_rdata <= hit_word;
            end
          end else begin
            victim_way <= victim_sel_way;
            beat       <= '0;
            if (valid_bits[cur_idx][victim_sel_way] && dirty_bits[cur_idx][victim_sel_way]) begin
              state   <= S_WB_AW;
              awvalid <= 1'b1;
              awaddr  <= {tag_mem[victim_sel_way][cur_idx], cur_idx, {(OFF_W+2){1'b0}}};
              awlen   <= LINE_LEN;
              awsize  <= AXI_SIZE_WORD;
              awburst <= AXI_BURST_INCR;
            end else begin
              state   <= S_RF_AR;
              arvalid <= 1'b1;
              araddr  <= line_base;
              arlen   <= LINE_LEN;
              arsize  <= AXI_SIZE_WORD;
              arburst <= AXI_BURST_INCR;
            end
          end
        end
        S_WB_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            state   <= S_WB_W;
            wvalid  <= 1'b1;
            wdata   <= data_mem[victim_way][cur_idx][{OFF_W{1'b0}}];
            wstrb   <= 4'hF;
            wlast   <= 1'b0;
          end
        end
        S_WB_W: begin
          if (wready) begin
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              beat   <= '0;
              state  <= S_WB_B;
            end else begin
              beat  <= beat_next;
              wdata <= data_mem[victim_way][cur_idx][beat_next];
              wlast <= (beat_next == LAST_BEAT);
            end
          end
        end
        S_WB_B: begin
          if (bvalid) begin
            bready  <= 1'b0;
            state   <= S_RF_AR;
            arvalid <= 1'b1;
            araddr  <= line_base;
            arlen   <= LINE_LEN;
            arsize  <= AXI_SIZE_WORD;
            arburst <= AXI_BURST_INCR;
          end
        end
        S_RF_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat    <= '0;
            state   <= S_RF_R;
          end
        end
        S_RF_R: begin
          if (rvalid) begin
            data_mem[victim_way][cur_idx][beat] <= beat_word;
            beat <= beat_next;
            if (beat == cur_off) begin
              captured <= rdata;
            end
            // rlast alone terminates the burst, whatever the beat count says
            if (rlast) begin
              rready     <= 1'b0;
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= is_store ? 32'h0 : load_word;
              valid_bits[cur_idx][victim_way] <= 1'b1;
              dirty_bits[cur_idx][victim_way] <= is_store;
              tag_mem[victim_way][cur_idx]    <= cur_tag;
              if (victim_way == rr_ptr[cur_idx]) begin
                rr_ptr[cur_idx] <= rr_next;
              end
            end
          end
        end
        S_UC_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_UC_R;
          end
        end
        S_UC_R: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= rdata;
            state      <= S_RESP;
          end
        end
        S_UC_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wdata   <= cur_wdata;
            wstrb   <= cur_wen;
            wlast   <= 1'b1;
            state   <= S_UC_W;
          end
        end
        S_UC_W: begin
          if (wready) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
            bready <= 1'b1;
            state  <= S_UC_B;
          end
        end
        S_UC_B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= 32'h0;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_nway_wb.sv
// Directed bench for dcache_nway_wb: the bench plays CPU and AXI slave, expected values are hand-computed.
module tb_dcache_nway_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_uncached = 1'b0;
  logic [3:0]  req_wen = 4'h0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] rdata = 32'h0;

  int n_cmp = 0;
  int n_err = 0;
  int resp_cnt = 0;
  int cnt0;

  dcache_nway_wb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_uncached(req_uncached),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resp_valid === 1'b1) resp_cnt <= resp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present one request while IDLE; returns in the cycle after acceptance.
  task automatic request(input logic [31:0] addr, input logic [3:0] wen,
                         input logic [31:0] wd, input logic unc);
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_wdata = wd; req_uncached = unc;
    tick();
    req_valid = 1'b0; req_uncached = 1'b0;
    chk1("req_ready_busy", req_ready, 1'b0);
    chk1("resp_early", resp_valid, 1'b0);
  endtask

  task automatic finish_resp(input string tag, input logic [31:0] exp);
    chk1({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    tick();
    chk1({tag, "_resp_drop"}, resp_valid, 1'b0);
  endtask

  // Hit: response two cycles after acceptance with no AXI traffic.
  task automatic hit_access(input string tag, input logic [31:0] addr, input logic [3:0] wen,
                            input logic [31:0] wd, input logic [31:0] exp);
    request(addr, wen, wd, 1'b0);
    tick();
    chk1({tag, "_no_ar"}, arvalid, 1'b0);
    chk1({tag, "_no_aw"}, awvalid, 1'b0);
    finish_resp(tag, exp);
  endtask

  task automatic serve_refill(input logic [31:0] base, input logic [31:0] d0,
                              input int ar_delay, input int gap);
    for (int i = 0; i < 20 && arvalid !== 1'b1; i++) tick();
    chk1("arvalid_seen", arvalid, 1'b1);
    chk("araddr", araddr, base);
    chk("arlen", {24'h0, arlen}, 32'd3);
    chk("arsize", {29'h0, arsize}, 32'd2);
    for (int i = 0; i < ar_delay; i++) tick();
    chk("ar_held", {araddr[31:1], arvalid}, {base[31:1], 1'b1});
    arready = 1'b1; tick(); arready = 1'b0;
    chk1("rready", rready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      rvalid = 1'b1; rdata = d0 + 32'(k); rlast = (k == 3);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  // words = {w3, w2, w1, w0}; stop_beat < 4 leaves the burst parked before that beat.
  task automatic serve_wb(input logic [31:0] base, input logic [127:0] words, input int stop_beat);
    for (int i = 0; i < 20 && awvalid !== 1'b1; i++) tick();
    chk1("awvalid_seen", awvalid, 1'b1);
    chk("awaddr", awaddr, base);
    chk("awlen", {24'h0, awlen}, 32'd3);
    chk1("w_before_aw", wvalid, 1'b0);
    awready = 1'b1; tick(); awready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < stop_beat) begin
        chk1("wvalid", wvalid, 1'b1);
        chk("wdata", wdata, words[32*k +: 32]);
        chk("wstrb", {28'h0, wstrb}, 32'hF);
        chk1("wlast", wlast, (k == 3));
        wready = 1'b1; tick(); wready = 1'b0;
      end
    end
    if (stop_beat > 3) begin
      chk1("bready", bready, 1'b1);
      bvalid = 1'b1; tick(); bvalid = 1'b0;
    end
  endtask

  initial begin
    tick(); tick(); tick();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_bus_valids", {27'h0, arvalid, awvalid, wvalid, rready, bready}, 32'h0);
    rst = 1'b0;

    // Cold load: refill set 0 way 0
    request(32'h0000_1004, 4'h0, 32'h0, 1'b0);
    chk1("lookup_no_ar", arvalid, 1'b0);
    serve_refill(32'h0000_1000, 32'hA0, 0, 0);
    finish_resp("cold_load", 32'h0000_00A1);
    hit_access("repeat_hit", 32'h0000_1004, 4'h0, 32'h0, 32'h0000_00A1);
    hit_access("store_hit", 32'h0000_1004, 4'b0011, 32'h1234_5678, 32'h0);
    hit_access("reload", 32'h0000_1004, 4'h0, 32'h0, 32'h0000_5678);

    // Fill way 1, then evict the dirty way 0 line
    request(32'h0000_2000, 4'h0, 32'h0, 1'b0);
    serve_refill(32'h0000_2000, 32'hE0, 0, 0);
    finish_resp("fill_way1", 32'h0000_00E0);
    request(32'h0000_3008, 4'h0, 32'h0, 1'b0);
    serve_wb(32'h0000_1000, {32'hA3, 32'hA2, 32'h0000_5678, 32'hA0}, 4);
    serve_refill(32'h0000_3000, 32'hF0, 0, 0);
    finish_resp("evict_set0", 32'h0000_00F2);

    // Store miss with slow arready and gapped beats
    cnt0 = resp_cnt;
    request(32'h0000_4100, 4'hF, 32'hCAFE_0001, 1'b0);
    serve_refill(32'h0000_4100, 32'hB0, 5, 1);
    finish_resp("store_miss", 32'h0);
    tick();
    chk("store_miss_pulses", 32'(resp_cnt - cnt0), 32'd1);
    hit_access("store_miss_merged", 32'h0000_4100, 4'h0, 32'h0, 32'hCAFE_0001);

    // Second way of set 0x10, then third tag evicts the dirty rr_ptr way
    request(32'h0000_5104, 4'h0, 32'h0, 1'b0);
    serve_refill(32'h0000_5100, 32'hC0, 0, 0);
    finish_resp("fill_10_way1", 32'h0000_00C1);
    request(32'h0000_6108, 4'h0, 32'h0, 1'b0);
    serve_wb(32'h0000_4100, {32'hB3, 32'hB2, 32'hB1, 32'hCAFE_0001}, 4);
    serve_refill(32'h0000_6100, 32'hD0, 0, 0);
    finish_resp("evict_10", 32'h0000_00D2);
    // rr_ptr now 1: clean way 1 goes next, way 0 survives
    request(32'h0000_7100, 4'h0, 32'h0, 1'b0);
    serve_refill(32'h0000_7100, 32'h70, 0, 0);
    chk1("rr_no_wb", awvalid, 1'b0);
    finish_resp("rr_victim", 32'h0000_0070);
    hit_access("rr_keep_way0", 32'h0000_6100, 4'h0, 32'h0, 32'h0000_00D0);

    // Uncached store
    request(32'h1FD0_0000, 4'b1000, 32'hDEAD_BEEF, 1'b1);
    chk1("uc_awvalid", awvalid, 1'b1);
    chk("uc_awaddr", awaddr, 32'h1FD0_0000);
    chk("uc_awlen", {24'h0, awlen}, 32'd0);
    awready = 1'b1; tick(); awready = 1'b0;
    chk("uc_wdata", wdata, 32'hDEAD_BEEF);
    chk("uc_wstrb_wlast", {27'h0, wstrb, wlast}, {27'h0, 4'b1000, 1'b1});
    wready = 1'b1; tick(); wready = 1'b0;
    chk1("uc_bready", bready, 1'b1);
    chk1("uc_no_resp_before_b", resp_valid, 1'b0);
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    finish_resp("uc_store", 32'h0);

    // Uncached load
    request(32'h1FD0_0004, 4'h0, 32'h0, 1'b1);
    chk("uc_araddr", araddr, 32'h1FD0_0004);
    chk("uc_arlen", {24'h0, arlen}, 32'd0);
    arready = 1'b1; tick(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h55AA_33CC; rlast = 1'b1; tick();
    rvalid = 1'b0; rlast = 1'b0;
    finish_resp("uc_load", 32'h55AA_33CC);
    hit_access("uc_arrays_intact", 32'h0000_3008, 4'h0, 32'h0, 32'h0000_00F2);

    // Reset in the middle of a write-back burst
    hit_access("dirty_way1", 32'h0000_2000, 4'hF, 32'h1111_2222, 32'h0);
    request(32'h0000_8000, 4'h0, 32'h0, 1'b0);
    serve_wb(32'h0000_2000, {32'hE3, 32'hE2, 32'hE1, 32'h1111_2222}, 2);
    chk("wb_beat2_data", wdata, 32'h0000_00E2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valids", {29'h0, awvalid, wvalid, arvalid}, 32'h0);
    chk1("mid_rst_ready", req_ready, 1'b1);
    request(32'h0000_3008, 4'h0, 32'h0, 1'b0);
    serve_refill(32'h0000_3000, 32'h30, 0, 0);
    finish_resp("post_rst_miss", 32'h0000_0032);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
